// File: rtl/thread_spawner_pkg.sv
// Shared inter-CPU message codes and spawn-response codes for the thread scheduler.
package thread_spawner_pkg;

  localparam logic [7:0] MSG_SPAWN = 8'h10;
  localparam logic [7:0] MSG_KILL  = 8'h11;

  localparam logic [1:0] NACK_NONE   = 2'd0;
  localparam logic [1:0] NACK_NOSLOT = 2'd1;
  localparam logic [1:0] NACK_FULL   = 2'd2;

  typedef enum logic {
    ST_IDLE,
    ST_RESPOND
  } state_e;

endpackage

// File: rtl/thread_spawner_slot_prio_enc.sv
// Lowest-index priority encoder over the free-slot mask.
module slot_prio_enc #(
  parameter int unsigned PROC_QUANTITY = 8
) (
  input  logic [PROC_QUANTITY-1:0]         free_mask,
  output logic [$clog2(PROC_QUANTITY)-1:0] free_idx,
  output logic                             any_free
);

  localparam int unsigned IDW = $clog2(PROC_QUANTITY);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    free_idx = '0;
    any_free = |free_mask;
    for (int i = PROC_QUANTITY - 1; i >= 0; i--) begin
      if (free_mask[i]) free_idx = IDW'(i);
    end
  end

endmodule

// File: rtl/thread_spawner.sv
// Decodes spawn/kill messages, allocates thread slots and queues descriptors
// toward the scheduler over a valid/ready push interface.
module thread_spawner
  import thread_spawner_pkg::*;
#(
  parameter int unsigned PROC_QUANTITY = 8,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned DATA_W        = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       cpu_msg,
  input  logic [DATA_W-1:0]                msg_arg,
  output logic                             spawn_ack,
  output logic                             spawn_nack,
  output logic [1:0]                       nack_reason,
  output logic [$clog2(PROC_QUANTITY)-1:0] spawn_id,
  output logic                             kill_err,
  output logic                             push_valid,
  output logic [DATA_W-1:0]                push_proc,
  input  logic                             push_ready,
  output logic [$clog2(PROC_QUANTITY):0]   free_cnt
);

  localparam int unsigned IDW = $clog2(PROC_QUANTITY);
  localparam int unsigned FCW = IDW + 1;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;

  state_e                   state_q, state_d;
  logic [PROC_QUANTITY-1:0] busy_q, busy_d;
  logic [FCW-1:0]           free_cnt_q, free_cnt_d;
  logic [DATA_W-1:0]        mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]        mem_d [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     spawn_ack_q, spawn_ack_d;
  logic                     spawn_nack_q, spawn_nack_d;
  logic [1:0]               nack_reason_q, nack_reason_d;
  logic [IDW-1:0]           spawn_id_q, spawn_id_d;
  logic                     kill_err_q, kill_err_d;
  logic                     push_valid_q, push_valid_d;
  logic [DATA_W-1:0]        push_proc_q, push_proc_d;

  logic [IDW-1:0]           free_idx;
  logic                     any_free;
  logic                     is_spawn, is_kill, accept, pop;
  logic [IDW-1:0]           kill_idx;

  slot_prio_enc #(.PROC_QUANTITY(PROC_QUANTITY)) u_enc (
    .free_mask (~busy_q),
    .free_idx  (free_idx),
    .any_free  (any_free)
  );

  assign is_spawn = (cpu_msg == MSG_SPAWN);
  assign is_kill  = (cpu_msg == MSG_KILL);
  assign kill_idx = msg_arg[IDW-1:0];
  assign pop      = (count_q != '0) && push_ready;
  // Full is judged on the pre-edge count, so a same-cycle pop never makes room.
  assign accept   = is_spawn && any_free && (count_q != CW'(FIFO_DEPTH));

  always_comb begin
    state_d       = ST_IDLE;
    busy_d        = busy_q;
    free_cnt_d    = free_cnt_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    spawn_ack_d   = 1'b0;
    spawn_nack_d  = 1'b0;
    nack_reason_d = NACK_NONE;
    spawn_id_d    = '0;
    kill_err_d    = 1'b0;

    case (state_q)
      ST_IDLE:    state_d = (is_spawn || is_kill) ? ST_RESPOND : ST_IDLE;
      ST_RESPOND: state_d = (is_spawn || is_kill) ? ST_RESPOND : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (is_spawn) begin
      if (!any_free) begin
        spawn_nack_d  = 1'b1;
        nack_reason_d = NACK_NOSLOT;
      end else if (!accept) begin
        spawn_nack_d  = 1'b1;
        nack_reason_d = NACK_FULL;
      end else begin
        spawn_ack_d      = 1'b1;
        spawn_id_d       = free_idx;
        busy_d[free_idx] = 1'b1;
        free_cnt_d       = free_cnt_q - FCW'(1);
        mem_d[wr_ptr_q]  = msg_arg;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
    end

    if (is_kill) begin
      if ((msg_arg < DATA_W'(PROC_QUANTITY)) && busy_q[kill_idx]) begin
        busy_d[kill_idx] = 1'b0;
        free_cnt_d       = free_cnt_q + FCW'(1);
      end else begin
        kill_err_d = 1'b1;
      end
    end

    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(accept) - CW'(pop);

    // Registered head: a write landing on the new read pointer forwards the argument.
    push_valid_d = (count_d != '0);
    push_proc_d  = (accept && (wr_ptr_q == rd_ptr_d)) ? msg_arg : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      busy_q        <= '0;
      free_cnt_q    <= FCW'(PROC_QUANTITY);
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      spawn_ack_q   <= 1'b0;
      spawn_nack_q  <= 1'b0;
      nack_reason_q <= NACK_NONE;
      spawn_id_q    <= '0;
      kill_err_q    <= 1'b0;
      push_valid_q  <= 1'b0;
      push_proc_q   <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      free_cnt_q    <= free_cnt_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      spawn_ack_q   <= spawn_ack_d;
      spawn_nack_q  <= spawn_nack_d;
      nack_reason_q <= nack_reason_d;
      spawn_id_q    <= spawn_id_d;
      kill_err_q    <= kill_err_d;
      push_valid_q  <= push_valid_d;
      push_proc_q   <= push_proc_d;
    end
  end

  assign spawn_ack   = spawn_ack_q;
  assign spawn_nack  = spawn_nack_q;
  assign nack_reason = nack_reason_q;
  assign spawn_id    = spawn_id_q;
  assign kill_err    = kill_err_q;
  assign push_valid  = push_valid_q;
  assign push_proc   = push_proc_q;
  assign free_cnt    = free_cnt_q;

endmodule
